// File: rtl/hc595_tx_if.sv
// rtl/hc595_tx_if.sv - pattern request and 74HC595 pin bundle for hc595_tx
interface hc595_tx_if;
  logic [7:0] data_in;
  logic       start;
  logic       busy;
  logic       done;
  logic       ser;
  logic       sclk;
  logic       rclk;

  modport master (output data_in, start, input busy, done, ser, sclk, rclk);
  modport slave  (input data_in, start, output busy, done, ser, sclk, rclk);
endinterface

// File: rtl/hc595_tx.sv
// rtl/hc595_tx.sv - serialises an 8-bit pattern into an external 74HC595 via ser/sclk/rclk
module hc595_tx #(
  parameter int unsigned CLK_DIV   = 4,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          AUTO_SEND = 1'b1
) (
  input  logic      clk_i,
  input  logic      rst_i,
  hc595_tx_if.slave bus_if
);
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_e;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  shadow_q, shadow_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ser_q, ser_d;
  logic        sclk_q, sclk_d;
  logic        rclk_q, rclk_d;
  logic        trigger;
  logic        div_wrap;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      div_q    <= 16'd0;
      bit_q    <= 3'd0;
      shreg_q  <= 8'h00;
      shadow_q <= 8'h00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ser_q    <= 1'b0;
      sclk_q   <= 1'b0;
      rclk_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      shadow_q <= shadow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ser_q    <= ser_d;
      sclk_q   <= sclk_d;
      rclk_q   <= rclk_d;
    end
  end

  assign trigger  = bus_if.start | (AUTO_SEND & (bus_if.data_in != shadow_q));
  assign div_wrap = (div_q == DIV_LAST);

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    shadow_d = shadow_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ser_d    = ser_q;
    sclk_d   = sclk_q;
    rclk_d   = rclk_q;

    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d  = SHIFT;
          shreg_d  = bus_if.data_in;
          shadow_d = bus_if.data_in;
          busy_d   = 1'b1;
          ser_d    = MSB_FIRST ? bus_if.data_in[7] : bus_if.data_in[0];
          sclk_d   = 1'b0;
          div_d    = 16'd0;
          bit_d    = 3'd0;
        end
      end

      SHIFT: begin
        if (!div_wrap) begin
          div_d = div_q + 16'd1;
        end else begin
          div_d = 16'd0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // ser only moves on the falling sclk edge, keeping it stable around the rise
            sclk_d = 1'b0;
            bit_d  = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = LATCH;
              rclk_d  = 1'b1;
            end else begin
              shreg_d = MSB_FIRST ? {shreg_q[6:0], 1'b0} : {1'b0, shreg_q[7:1]};
              ser_d   = MSB_FIRST ? shreg_q[6] : shreg_q[1];
            end
          end
        end
      end

      LATCH: begin
        if (!div_wrap) begin
          div_d = div_q + 16'd1;
        end else begin
          div_d   = 16'd0;
          rclk_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus_if.busy = busy_q;
  assign bus_if.done = done_q;
  assign bus_if.ser  = ser_q;
  assign bus_if.sclk = sclk_q;
  assign bus_if.rclk = rclk_q;
endmodule

// File: tb/tb_hc595_tx.sv
// tb/tb_hc595_tx.sv - directed self-checking bench for hc595_tx with a 74HC595 model
module tb_hc595_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] din [4];
  logic       go  [4];

  hc595_tx_if if_a ();
  hc595_tx_if if_b ();
  hc595_tx_if if_c ();
  hc595_tx_if if_d ();

  assign if_a.data_in = din[0];
  assign if_a.start   = go[0];
  assign if_b.data_in = din[1];
  assign if_b.start   = go[1];
  assign if_c.data_in = din[2];
  assign if_c.start   = go[2];
  assign if_d.data_in = din[3];
  assign if_d.start   = go[3];

  hc595_tx #(.CLK_DIV(2), .MSB_FIRST(1'b1), .AUTO_SEND(1'b0)) u_a (.clk_i(clk), .rst_i(rst), .bus_if(if_a));
  hc595_tx #(.CLK_DIV(2), .MSB_FIRST(1'b0), .AUTO_SEND(1'b0)) u_b (.clk_i(clk), .rst_i(rst), .bus_if(if_b));
  hc595_tx #(.CLK_DIV(2), .MSB_FIRST(1'b1), .AUTO_SEND(1'b1)) u_c (.clk_i(clk), .rst_i(rst), .bus_if(if_c));
  hc595_tx #(.CLK_DIV(1), .MSB_FIRST(1'b1), .AUTO_SEND(1'b0)) u_d (.clk_i(clk), .rst_i(rst), .bus_if(if_d));

  // Observed instance, packed as {busy, done, ser, sclk, rclk}
  int         sel = 0;
  logic [4:0] m_out;
  always_comb begin
    case (sel)
      0:       m_out = {if_a.busy, if_a.done, if_a.ser, if_a.sclk, if_a.rclk};
      1:       m_out = {if_b.busy, if_b.done, if_b.ser, if_b.sclk, if_b.rclk};
      2:       m_out = {if_c.busy, if_c.done, if_c.ser, if_c.sclk, if_c.rclk};
      default: m_out = {if_d.busy, if_d.done, if_d.ser, if_d.sclk, if_d.rclk};
    endcase
  end

  int errors = 0;
  int checks = 0;
  int busy_tot = 0, done_tot = 0, rclk_hi_tot = 0, rclk_rise_tot = 0, bit_tot = 0;
  int ser_err = 0, done_err = 0;
  int s_busy, s_done, s_rclk_hi, s_rclk_rise, s_bit;
  logic [7:0] hc_sr = 8'h00;
  logic [7:0] hc_q  = 8'h00;
  logic p_busy = 1'b0, p_ser = 1'b0, p_sclk = 1'b0, p_rclk = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample on the falling edge and advance the 74HC595 model
  task automatic step();
    logic c_busy, c_done, c_ser, c_sclk, c_rclk;
    @(negedge clk);
    {c_busy, c_done, c_ser, c_sclk, c_rclk} = m_out;
    if (c_busy) busy_tot++;
    if (c_done) begin
      done_tot++;
      if (!(p_busy && !c_busy)) done_err++;
    end
    if (c_rclk) rclk_hi_tot++;
    if (c_rclk && !p_rclk) begin
      rclk_rise_tot++;
      hc_q = hc_sr;
    end
    if (c_sclk && !p_sclk) begin
      hc_sr = {hc_sr[6:0], c_ser};
      bit_tot++;
    end
    if (c_sclk && p_sclk && (c_ser != p_ser)) ser_err++;
    p_busy = c_busy;
    p_ser  = c_ser;
    p_sclk = c_sclk;
    p_rclk = c_rclk;
  endtask

  task automatic snap();
    s_busy      = busy_tot;
    s_done      = done_tot;
    s_rclk_hi   = rclk_hi_tot;
    s_rclk_rise = rclk_rise_tot;
    s_bit       = bit_tot;
  endtask

  task automatic pulse_start(input logic [7:0] d);
    din[sel] = d;
    go[sel]  = 1'b1;
    step();
    go[sel]  = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (!m_out[3] && n < budget);
    check(tag, 32'(m_out[3]), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      din[i] = 8'h00;
      go[i]  = 1'b0;
    end

    rst = 1'b1;
    step();
    step();
    for (int s = 0; s < 4; s++) begin
      sel = s;
      step();
      check("reset_outputs", 32'(m_out), 32'h0);
    end
    rst = 1'b0;
    sel = 0;
    step();

    // MSB-first 8'hA5, CLK_DIV=2
    snap();
    pulse_start(8'hA5);
    check("t1_first_cycle", 32'({m_out[4], m_out[2], m_out[1]}), 32'b110);
    repeat (40) step();
    check("t1_busy_len",    32'(busy_tot - s_busy), 32'd34);
    check("t1_nbits",       32'(bit_tot - s_bit), 32'd8);
    check("t1_bits",        32'(hc_sr), 32'hA5);
    check("t1_rclk_pulses", 32'(rclk_rise_tot - s_rclk_rise), 32'd1);
    check("t1_rclk_width",  32'(rclk_hi_tot - s_rclk_hi), 32'd2);
    check("t1_done_count",  32'(done_tot - s_done), 32'd1);
    check("t1_latched",     32'(hc_q), 32'hA5);
    check("t1_ser_idle",    32'(m_out[2]), 32'd1);

    // LSB-first 8'h01: sampled order 1,0,0,0,0,0,0,0
    sel = 1;
    step();
    snap();
    pulse_start(8'h01);
    repeat (40) step();
    check("t2_bits",       32'(hc_sr), 32'h80);
    check("t2_done_count", 32'(done_tot - s_done), 32'd1);
    check("t2_busy_len",   32'(busy_tot - s_busy), 32'd34);
    check("t2_ser_idle",   32'(m_out[2]), 32'd0);

    // start during busy is ignored
    sel = 0;
    step();
    snap();
    pulse_start(8'h3C);
    repeat (9) step();
    go[0] = 1'b1;
    step();
    go[0] = 1'b0;
    repeat (50) step();
    check("t3_busy_len",    32'(busy_tot - s_busy), 32'd34);
    check("t3_rclk_pulses", 32'(rclk_rise_tot - s_rclk_rise), 32'd1);
    check("t3_done_count",  32'(done_tot - s_done), 32'd1);
    check("t3_latched",     32'(hc_q), 32'h3C);

    // AUTO_SEND: no send at 8'h00, send on change, back-to-back on mid-transfer change
    sel = 2;
    step();
    snap();
    repeat (5) step();
    check("t4_no_send_zero", 32'(busy_tot - s_busy), 32'd0);
    snap();
    din[2] = 8'h80;
    step();
    check("t4_auto_start", 32'(m_out[4]), 32'd1);
    repeat (9) step();
    din[2] = 8'h01;
    wait_done(60, "t4_done1");
    check("t4_latched1", 32'(hc_q), 32'h80);
    step();
    check("t4_back_to_back", 32'(m_out[4]), 32'd1);
    wait_done(60, "t4_done2");
    check("t4_latched2", 32'(hc_q), 32'h01);
    repeat (5) step();
    check("t4_idle_after",   32'(m_out[4]), 32'd0);
    check("t4_busy_total",   32'(busy_tot - s_busy), 32'd68);
    check("t4_done_count",   32'(done_tot - s_done), 32'd2);
    check("t4_rclk_pulses",  32'(rclk_rise_tot - s_rclk_rise), 32'd2);

    // reset mid-transfer aborts without latching
    sel = 0;
    step();
    snap();
    pulse_start(8'hF0);
    repeat (11) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_reset_outputs", 32'(m_out), 32'h0);
    repeat (40) step();
    check("t5_no_rclk", 32'(rclk_rise_tot - s_rclk_rise), 32'd0);
    check("t5_kept",    32'(hc_q), 32'h01);
    snap();
    pulse_start(8'hC3);
    wait_done(60, "t5_done");
    check("t5_latched",  32'(hc_q), 32'hC3);
    check("t5_busy_len", 32'(busy_tot - s_busy), 32'd34);

    // all 256 patterns through the 74HC595 model, CLK_DIV=1
    sel = 3;
    step();
    snap();
    for (int i = 0; i < 256; i++) begin
      pulse_start(8'(i));
      wait_done(30, "t6_done");
      check("t6_pattern", 32'(hc_q), 32'(i));
    end
    check("t6_busy_total", 32'(busy_tot - s_busy), 32'd4352);
    check("t6_bit_total",  32'(bit_tot - s_bit), 32'd2048);

    check("ser_stable_while_sclk_high", 32'(ser_err), 32'd0);
    check("done_on_first_idle_cycle",   32'(done_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
